// File: rtl/kpd_pkg.sv
// Shared types for the keypad command parser: token codes, parser states and
// the packed motor command carried through the command queue.
package kpd_pkg;

   localparam logic [3:0] TOK_SPACE    = 4'd10;
   localparam logic [3:0] TOK_ENTER    = 4'd11;
   localparam logic [3:0] TOK_FORWARD  = 4'd12;
   localparam logic [3:0] TOK_BACKWARD = 4'd13;
   localparam logic [3:0] TOK_INVALID  = 4'd14;

   // Field widths of the queued command; they track the parser's default
   // N_MOTORS=4 and ANGLE_W=9.
   localparam int CMD_MOTOR_W = 2;
   localparam int CMD_ANGLE_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      MOTOR,
      DIR,
      DIGITS,
      ERROR
   } kpd_state_e;

   typedef struct packed {
      logic [CMD_MOTOR_W-1:0] motor;
      logic                   dir;
      logic [CMD_ANGLE_W-1:0] angle;
   } kpd_cmd_t;

endpackage

// File: rtl/kpd_cmd_fifo.sv
// First-word fall-through queue of parsed motor commands. A push into a full
// queue is still accepted when the head is popped in the same cycle.
module kpd_cmd_fifo
   import kpd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  kpd_cmd_t push_data_i,
   output logic     push_ok_o,
   input  logic     pop_i,
   output kpd_cmd_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   kpd_cmd_t         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_q;
   logic [PTR_W-1:0] wr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_pop;
   logic             do_push;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign do_pop    = pop_i && !empty_o;
   assign do_push   = push_i && (!full_o || do_pop);
   assign push_ok_o = do_push;
   assign head_o    = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/kpd_cmd_parser.sv
// Keypad command parser: turns "<motor> SPACE <dir> <digits> ENTER" token
// streams into queued motor commands. KPD_SPACE_TERM_EN lets SPACE terminate.
module kpd_cmd_parser
   import kpd_pkg::*;
#(
   parameter int N_MOTORS   = 4,
   parameter int MAX_DIGITS = 3,
   parameter int MAX_ANGLE  = 360,
   parameter int ANGLE_W    = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        in_Clk,
   input  logic                        in_Rst,
   input  logic                        i_ena,
   input  logic [3:0]                  i_data_dec,
   output logic                        o_cmd_valid,
   input  logic                        i_cmd_ready,
   output logic [$clog2(N_MOTORS)-1:0] o_cmd_motor,
   output logic                        o_cmd_dir,
   output logic [ANGLE_W-1:0]          o_cmd_angle,
   output logic                        out_led_ini,
   output logic                        o_err,
   output logic                        o_fifo_full
);

   localparam int MOTOR_W = $clog2(N_MOTORS);
   localparam int ACC_W   = ANGLE_W + 4;
   localparam int CNT_W   = $clog2(MAX_DIGITS + 2);

   kpd_state_e       state_q;
   logic             ena_q;
   logic [MOTOR_W-1:0] motor_q;
   logic             dir_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic             tok_stb;
   logic             is_digit;
   logic             is_term;
   logic             motor_ok;
   logic             commit;
   logic             pop;
   logic             push_ok;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ACC_W-1:0] acc_d;
   logic [CNT_W-1:0] cnt_d;
   kpd_cmd_t         push_cmd;
   kpd_cmd_t         head_cmd;

   assign tok_stb  = i_ena && !ena_q;
   assign is_digit = (i_data_dec <= 4'd9);
   assign motor_ok = (i_data_dec != 4'd0) && (int'(i_data_dec) <= N_MOTORS);
`ifdef KPD_SPACE_TERM_EN
   assign is_term  = (i_data_dec == TOK_ENTER) || (i_data_dec == TOK_SPACE);
`else
   assign is_term  = (i_data_dec == TOK_ENTER);
`endif

   // The accumulator is wider than the angle so an out-of-range value is
   // seen as such rather than wrapping into range.
   assign acc_d = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(i_data_dec);
   assign cnt_d = cnt_q + CNT_W'(1);

   assign commit = tok_stb && (state_q == DIGITS) && is_term &&
                   (cnt_q != '0) && (acc_q <= ACC_W'(MAX_ANGLE));
   assign pop    = o_cmd_valid && i_cmd_ready;

   assign push_cmd.motor = CMD_MOTOR_W'(motor_q);
   assign push_cmd.dir   = dir_q;
   assign push_cmd.angle = CMD_ANGLE_W'(acc_q);

   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         state_q <= IDLE;
         ena_q   <= 1'b1;
         motor_q <= '0;
         dir_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         ena_q <= i_ena;
         err_q <= 1'b0;
         if (tok_stb) begin
            case (state_q)
               IDLE: begin
                  if (i_data_dec >= TOK_INVALID || !motor_ok) begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end else begin
                     motor_q <= MOTOR_W'(i_data_dec - 4'd1);
                     state_q <= MOTOR;
                  end
               end
               MOTOR: begin
                  if (i_data_dec == TOK_SPACE) begin
                     state_q <= DIR;
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
               DIR: begin
                  if (i_data_dec == TOK_FORWARD || i_data_dec == TOK_BACKWARD) begin
                     dir_q   <= (i_data_dec == TOK_FORWARD);
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= DIGITS;
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
               DIGITS: begin
                  if (is_digit) begin
                     if (int'(cnt_d) > MAX_DIGITS) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                     end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                     end
                  end else if (is_term) begin
                     // Range failures and a full queue both reject here.
                     state_q <= IDLE;
                     err_q   <= !(commit && push_ok);
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
               ERROR: begin
                  if (is_term) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   kpd_cmd_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (in_Clk),
      .rst_i      (in_Rst),
      .push_i     (commit),
      .push_data_i(push_cmd),
      .push_ok_o  (push_ok),
      .pop_i      (pop),
      .head_o     (head_cmd),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign o_cmd_valid = !fifo_empty;
   assign o_cmd_motor = MOTOR_W'(head_cmd.motor);
   assign o_cmd_dir   = head_cmd.dir;
   assign o_cmd_angle = ANGLE_W'(head_cmd.angle);
   assign o_fifo_full = fifo_full;
   assign out_led_ini = (state_q == IDLE);
   assign o_err       = err_q;

endmodule

// File: tb/tb_kpd_cmd_parser.sv
// Scoreboard bench for kpd_cmd_parser; the SPACE-terminator scenario follows
// KPD_SPACE_TERM_EN when it is defined for the build.
module tb_kpd_cmd_parser;
   import kpd_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       iEna;
   logic [3:0] iData;
   logic       iCmdReady;
   logic       oCmdValid;
   logic [1:0] oCmdMotor;
   logic       oCmdDir;
   logic [8:0] oCmdAngle;
   logic       outLedIni;
   logic       oErr;
   logic       oFifoFull;

   int compared    = 0;
   int mismatched  = 0;
   int errCount    = 0;
   int validCycles = 0;
   kpd_cmd_t expQ[$];

   kpd_cmd_parser dut (
      .in_Clk     (clk),
      .in_Rst     (rst),
      .i_ena      (iEna),
      .i_data_dec (iData),
      .o_cmd_valid(oCmdValid),
      .i_cmd_ready(iCmdReady),
      .o_cmd_motor(oCmdMotor),
      .o_cmd_dir  (oCmdDir),
      .o_cmd_angle(oCmdAngle),
      .out_led_ini(outLedIni),
      .o_err      (oErr),
      .o_fifo_full(oFifoFull)
   );

   always #5 clk = ~clk;

   // Scoreboard: every handshake at the head is checked against the oldest
   // expected command; inputs only change 2ns after a rising edge.
   always @(negedge clk) begin
      if (oErr) errCount++;
      if (oCmdValid) validCycles++;
      if (!rst && oCmdValid && iCmdReady) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_cmd got m=%0d d=%0d a=%0d expected none",
                     oCmdMotor, oCmdDir, oCmdAngle);
         end else begin
            kpd_cmd_t e;
            e = expQ.pop_front();
            if ({oCmdMotor, oCmdDir, oCmdAngle} !== e) begin
               mismatched++;
               $display("[TB] FAIL cmd got m=%0d d=%0d a=%0d expected m=%0d d=%0d a=%0d",
                        oCmdMotor, oCmdDir, oCmdAngle, e.motor, e.dir, e.angle);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic kpd_cmd_t mkCmd(input int m, input bit fwd, input int angle);
      kpd_cmd_t c;
      c.motor = CMD_MOTOR_W'(m - 1);
      c.dir   = fwd;
      c.angle = CMD_ANGLE_W'(angle);
      return c;
   endfunction

   task automatic sendTok(input logic [3:0] t, input int hold);
      iData = t;
      iEna  = 1'b1;
      repeat (hold) @(posedge clk);
      #2;
      iEna = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic sendHead(input int m, input bit fwd, input int angle, input int hold);
      sendTok(4'(m), hold);
      sendTok(TOK_SPACE, hold);
      sendTok(fwd ? TOK_FORWARD : TOK_BACKWARD, hold);
      if (angle >= 100) sendTok(4'(angle / 100), hold);
      if (angle >= 10) sendTok(4'((angle / 10) % 10), hold);
      sendTok(4'(angle % 10), hold);
   endtask

   task automatic sendCmd(input int m, input bit fwd, input int angle, input int hold,
                          input bit expectOk);
      sendHead(m, fwd, angle, hold);
      if (expectOk) expQ.push_back(mkCmd(m, fwd, angle));
      sendTok(TOK_ENTER, hold);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      iEna = 1'b1;
      iData = 4'd2;
      iCmdReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (outLedIni !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_led got=%b exp=1", outLedIni);
      end
      compared++;
      if ({oCmdValid, oErr, oFifoFull} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reset_flags got valid/err/full=%b exp=000",
                  {oCmdValid, oErr, oFifoFull});
      end
      compared++;
      if ({oCmdMotor, oCmdDir, oCmdAngle} !== 12'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_cmd got=%h exp=0", {oCmdMotor, oCmdDir, oCmdAngle});
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (outLedIni !== 1'b1 || errCount != 0) begin
         mismatched++;
         $display("[TB] FAIL held_ena_at_release got led=%b errs=%0d exp led=1 errs=0",
                  outLedIni, errCount);
      end
      @(posedge clk);
      #2;
      iEna = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic test_basic;
      int v0 = validCycles;
      int e0 = errCount;
      iCmdReady = 1'b1;
      sendHead(2, 1'b1, 128, 2);
      expQ.push_back(mkCmd(2, 1'b1, 128));
      iData = TOK_ENTER;
      iEna  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (oCmdValid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL commit_latency got valid=%b exp=1", oCmdValid);
      end
      @(posedge clk);
      #2;
      iEna = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (validCycles - v0 != 1 || errCount != e0) begin
         mismatched++;
         $display("[TB] FAIL basic_pulses got validCycles=%0d errs=%0d exp 1 and 0",
                  validCycles - v0, errCount - e0);
      end
      #2;
   endtask

   task automatic test_held_ena;
      int e0 = errCount;
      iCmdReady = 1'b1;
      sendCmd(4, 1'b0, 275, 4, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if (errCount != e0 || expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL held_ena got errs=%0d pending=%0d exp 0 and 0",
                  errCount - e0, expQ.size());
      end
      @(posedge clk);
      #2;
   endtask

   task automatic test_range;
      int e0 = errCount;
      iCmdReady = 1'b1;
      sendCmd(3, 1'b0, 361, 2, 1'b0);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || oCmdValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL angle_361 got errs=%0d valid=%b exp 1 and 0",
                  errCount - e0, oCmdValid);
      end
      @(posedge clk);
      #2;
      e0 = errCount;
      sendCmd(1, 1'b0, 0, 2, 1'b1);
      sendCmd(4, 1'b1, 360, 1, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if (errCount != e0 || expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL angle_edges got errs=%0d pending=%0d exp 0 and 0",
                  errCount - e0, expQ.size());
      end
      @(posedge clk);
      #2;
   endtask

   task automatic test_errors;
      int e0 = errCount;
      sendTok(4'd5, 2);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bad_motor got errs=%0d led=%b exp 1 and 0", errCount - e0, outLedIni);
      end
      @(posedge clk);
      #2;
      sendTok(TOK_ENTER, 1);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL error_exit got errs=%0d led=%b exp 1 and 1", errCount - e0, outLedIni);
      end
      @(posedge clk);
      #2;
      e0 = errCount;
      sendTok(4'd7, 1);
      sendTok(4'd9, 1);
      sendTok(TOK_ENTER, 1);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL seq_7_9 got errs=%0d led=%b exp 1 and 1", errCount - e0, outLedIni);
      end
      @(posedge clk);
      #2;
      e0 = errCount;
      sendHead(1, 1'b1, 123, 1);
      @(negedge clk);
      compared++;
      if (errCount != e0) begin
         mismatched++;
         $display("[TB] FAIL three_digits got errs=%0d exp 0", errCount - e0);
      end
      @(posedge clk);
      #2;
      sendTok(4'd4, 1);
      sendTok(TOK_ENTER, 1);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b1 || oCmdValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL four_digits got errs=%0d led=%b valid=%b exp 1,1,0",
                  errCount - e0, outLedIni, oCmdValid);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic test_fifo_full;
      int e0 = errCount;
      iCmdReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sendCmd(i + 1, i[0], 10 * i + 5, 1, 1'b1);
      end
      @(negedge clk);
      compared++;
      if (oFifoFull !== 1'b1 || errCount != e0) begin
         mismatched++;
         $display("[TB] FAIL fill_four got full=%b errs=%0d exp 1 and 0", oFifoFull, errCount - e0);
      end
      @(posedge clk);
      #2;
      sendCmd(2, 1'b1, 77, 1, 1'b0);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || oFifoFull !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL push_when_full got errs=%0d full=%b exp 1 and 1",
                  errCount - e0, oFifoFull);
      end
      @(posedge clk);
      #2;
      sendHead(3, 1'b1, 99, 1);
      expQ.push_back(mkCmd(3, 1'b1, 99));
      iData = TOK_ENTER;
      iEna = 1'b1;
      iCmdReady = 1'b1;
      @(posedge clk);
      #2;
      iEna = 1'b0;
      iCmdReady = 1'b0;
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || oFifoFull !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL push_pop_full got errs=%0d full=%b exp 1 and 1",
                  errCount - e0, oFifoFull);
      end
      @(posedge clk);
      #2;
      iCmdReady = 1'b1;
      for (int c = 0; c < 40 && oCmdValid; c++) @(posedge clk);
      @(negedge clk);
      compared++;
      if (oCmdValid !== 1'b0 || oFifoFull !== 1'b0 || expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain got valid=%b full=%b pending=%0d exp 0,0,0",
                  oCmdValid, oFifoFull, expQ.size());
      end
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset_flush;
      iCmdReady = 1'b0;
      sendCmd(1, 1'b1, 5, 1, 1'b1);
      sendHead(2, 1'b0, 12, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (oCmdValid !== 1'b0 || outLedIni !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_flush got valid=%b led=%b exp 0 and 1", oCmdValid, outLedIni);
      end
      expQ.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
      iCmdReady = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_space_term;
      int e0 = errCount;
      iCmdReady = 1'b1;
      sendHead(2, 1'b1, 128, 1);
`ifdef KPD_SPACE_TERM_EN
      expQ.push_back(mkCmd(2, 1'b1, 128));
      sendTok(TOK_SPACE, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if (errCount != e0 || outLedIni !== 1'b1 || expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL space_term got errs=%0d led=%b pending=%0d exp 0,1,0",
                  errCount - e0, outLedIni, expQ.size());
      end
`else
      sendTok(TOK_SPACE, 1);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL space_no_term got errs=%0d led=%b exp 1 and 0", errCount - e0, outLedIni);
      end
      @(posedge clk);
      #2;
      sendTok(TOK_SPACE, 1);
      sendTok(TOK_ENTER, 1);
      @(negedge clk);
      compared++;
      if (errCount - e0 != 1 || outLedIni !== 1'b1 || oCmdValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL space_error_exit got errs=%0d led=%b valid=%b exp 1,1,0",
                  errCount - e0, outLedIni, oCmdValid);
      end
`endif
      @(posedge clk);
      #2;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_held_ena;
      test_range;
      test_errors;
      test_fifo_full;
      test_reset_flush;
      test_space_term;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL leftover_expected got=%0d exp=0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/kpd_cmd_parser.md
Name: kpd_cmd_parser

Overview:
- Parametrised successor to the keypad data state machine.
- Parses decoded keypad tokens of the form `<motor> SPACE <FORWARD|BACKWARD> <angle digits> ENTER` into validated motor commands.
- Validated commands are queued in a small FIFO and handed to the N motor controllers over a valid/ready handshake.
- Sits between the keypad decoder and the per-motor PWM/step controllers.

Parameters:
- N_MOTORS, 4, number of addressable motors; valid motor digits are 1..N_MOTORS.
- MAX_DIGITS, 3, maximum angle digits per command.
- MAX_ANGLE, 360, largest legal angle in degrees (inclusive).
- ANGLE_W, 9, width of the angle field; must hold MAX_ANGLE.
- FIFO_DEPTH, 4, command queue depth (power of two, at least 2).

Ports:
- in_Clk  in  1  system clock
- in_Rst  in  1  reset, synchronous, active-high
- i_ena  in  1  token strobe from decoder; may stay high for several cycles
- i_data_dec  in  4  decoded token
- o_cmd_valid  out  1  FIFO head holds a command
- i_cmd_ready  in  1  downstream accepts head
- o_cmd_motor  out  $clog2(N_MOTORS)  motor index, zero-based (digit−1)
- o_cmd_dir  out  1  1 = FORWARD, 0 = BACKWARD
- o_cmd_angle  out  ANGLE_W  angle in degrees
- out_led_ini  out  1  parser idle, ready for a new command
- o_err  out  1  one-cycle pulse on a rejected command
- o_fifo_full  out  1  queue full

Behaviour:
- Reset values: state IDLE, FIFO empty, o_cmd_valid=0, o_cmd_motor/dir/angle=0, o_err=0, o_fifo_full=0, out_led_ini=1.
- Reset loads ena_q=1, so an i_ena held high through reset is not counted as a token.
- Token accept: a token is accepted at a clock edge where i_ena=1 and ena_q=0 (rising edge). i_data_dec is sampled at that edge; state updates at the same edge. Held strobes produce exactly one token.
- Token codes: 0–9 digit, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14 INVALID, 15 treated as INVALID.
- IDLE: digit in 1..N_MOTORS latches motor and goes to MOTOR. Any other token goes to ERROR.
- MOTOR: SPACE goes to DIR; any other token goes to ERROR.
- DIR: FORWARD/BACKWARD latches dir, clears acc and digit count, goes to DIGITS; any other token goes to ERROR.
- DIGITS, on a digit:
  - acc = acc*10 + digit, count+1.
  - If count would exceed MAX_DIGITS, go to ERROR.
  - acc is computed at ANGLE_W+4 bits internally so there is no wrap before the range check.
- DIGITS, on ENTER:
  - Commit if count≥1, acc≤MAX_ANGLE and the push is accepted; then go to IDLE.
  - Otherwise pulse o_err and go to IDLE.
- DIGITS, on any other token: go to ERROR.
- ERROR:
  - o_err pulses on the entry edge.
  - All tokens are discarded until ENTER, which returns to IDLE with no further pulse.
- out_led_ini = (state==IDLE).
- Commit latency: the command appears at the FIFO head one cycle after the ENTER edge if the FIFO was empty. o_cmd_valid rises on that cycle.
- FIFO:
  - First-word fall-through; head is presented on o_cmd_*.
  - Pop when o_cmd_valid && i_cmd_ready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (full + push + pop leaves count unchanged).
  - A push rejected because the FIFO is full drops the command and pulses o_err.
  - o_fifo_full = (count==FIFO_DEPTH).
- Downstream contract: o_cmd_* are stable while o_cmd_valid=1 and no pop has occurred.
- Angle 0 is legal. Leading zeros count toward MAX_DIGITS.
- Reset mid-command or with a non-empty FIFO flushes everything to the reset values.

Optional Feature:
- Macro: KPD_SPACE_TERM_EN.
- Defined: in DIGITS, SPACE acts as a terminator identical to ENTER (same checks, commit, latency). SPACE also exits ERROR like ENTER.
- Undefined: SPACE in DIGITS goes to ERROR, and only ENTER exits ERROR.

Decomposition:
- Package kpd_pkg: token localparams (SPACE, ENTER, FORWARD, BACKWARD, INVALID), parser state enum (IDLE, MOTOR, DIR, DIGITS, ERROR), and a packed command struct {motor, dir, angle} parametrised via localparams.
- One sub-module, kpd_cmd_fifo: generic FWFT FIFO over the packed struct, parameter FIFO_DEPTH, exposing push/pop/full/empty.

Test Plan:
- Tokens 2,SPACE,FORWARD,1,2,8,ENTER, each with i_ena high for 2 cycles, i_cmd_ready=1 → one command {motor=1, dir=1, angle=128}; o_cmd_valid high exactly 1 cycle; o_err never asserted.
- i_ena held high 4 cycles per token, and i_ena held high during and after reset → each token counted once; no token is generated at reset release.
- Tokens 3,SPACE,BACKWARD,3,6,1,ENTER → o_err pulses 1 cycle (361>360); FIFO is unchanged. Tokens 1,SPACE,BACKWARD,0,ENTER → {0,0,0} queued.
- Error cases:
  - Motor digit 5 (N_MOTORS=4) → ERROR.
  - Tokens 7,9 then ENTER → back to IDLE with only one o_err pulse.
  - Four digits with MAX_DIGITS=3 → ERROR on the fourth.
- i_cmd_ready=0, five valid commands → o_fifo_full after 4; fifth commit is dropped with an o_err pulse. Raising ready then drains 4 commands in order. A push and pop in the same cycle while full is accepted.
- With KPD_SPACE_TERM_EN: tokens 2,SPACE,FORWARD,1,2,8,SPACE → {1,1,128} committed. Without it: the same sequence → o_err, and the parser waits in ERROR for ENTER.
